// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed common-anode seven-segment driver. Scans DIGITS digits out of a
// packed hex word, with frame-synchronous double buffering, per-digit decimal
// points, optional leading-zero blanking and PWM brightness.
//
// Ports:
//   sys_clock   system clock
//   reset       asynchronous active-high reset
//   enable      1 = display on; 0 = dark (counters and loads keep running)
//   load        one-cycle strobe capturing value/dp_in/blank_lz into shadow
//   value       packed hex digits, digit 0 (rightmost) in value[3:0]
//   dp_in       decimal point request per digit
//   blank_lz    leading-zero blanking request, captured on load
//   brightness  PWM duty select, all-ones = always on
//   an_out      active-low anodes, bit k = digit k
//   sg_out      active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  one-cycle pulse in the first cycle of each frame
//   pending     a load sits in shadow and is not yet on display
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int PWM_BITS = 4
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an_out,
    output logic [7:0]            sg_out,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Segment pattern {dp,g..a}, active low, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PWM_BITS-1:0]  pwm_q, pwm_d;
    logic [4*DIGITS-1:0]  shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                 shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
    logic                 pending_q, pending_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [7:0]           sg_q, sg_d;

    logic                 presc_last;
    logic                 boundary;

    // zero_from[k] = nibbles DIGITS-1..k of the active value are all zero.
    logic [3:0]           nib [DIGITS];
    logic [DIGITS-1:0]    zero_from;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = active_val_q[4*gi +: 4];
        if (gi == DIGITS - 1) begin : g_top
            assign zero_from[gi] = (nib[gi] == 4'h0);
        end else begin : g_rest
            assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
        end
    end

    assign presc_last = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign boundary   = presc_last && (idx_q == IDX_W'(DIGITS - 1));

    // Counters and buffering.
    always_comb begin
        presc_d        = presc_last ? '0 : presc_q + PRESC_W'(1);
        idx_d          = idx_q;
        pwm_d          = pwm_q + PWM_BITS'(1);
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        active_val_d   = active_val_q;
        active_dp_d    = active_dp_q;
        active_blank_d = active_blank_q;
        pending_d      = pending_q;
        frame_tick_d   = boundary;

        if (presc_last) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // The active copy always takes the pre-edge shadow, so a load on the
        // boundary edge lands in shadow for the following frame.
        if (boundary) begin
            active_val_d   = shadow_val_q;
            active_dp_d    = shadow_dp_q;
            active_blank_d = shadow_blank_q;
            pending_d      = 1'b0;
        end
        if (load) begin
            shadow_val_d   = value;
            shadow_dp_d    = dp_in;
            shadow_blank_d = blank_lz;
            pending_d      = 1'b1;
        end
    end

    // Output decode for the digit currently being scanned.
    always_comb begin
        logic [3:0] cur_nib;
        logic       cur_dp;
        logic       cur_blank;
        logic       lit;
        logic [7:0] seg;

        cur_nib   = nib[idx_q];
        cur_dp    = active_dp_q[idx_q];
        cur_blank = active_blank_q && (idx_q != '0) && zero_from[idx_q];
        seg       = cur_blank ? 8'hFF : hex_to_seg(cur_nib);
        seg[7]    = ~cur_dp;
        // A blank digit without a dp has nothing to show, so its anode stays off.
        lit       = enable && (pwm_q <= brightness) && !(cur_blank && !cur_dp);
        an_d      = lit ? ~(DIGITS'(1) << idx_q) : '1;
        sg_d      = lit ? seg : 8'hFF;
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= '0;
            pwm_q          <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= 1'b0;
            active_val_q   <= '0;
            active_dp_q    <= '0;
            active_blank_q <= 1'b0;
            pending_q      <= 1'b0;
            frame_tick_q   <= 1'b0;
            an_q           <= '1;
            sg_q           <= 8'hFF;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            pwm_q          <= pwm_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            active_val_q   <= active_val_d;
            active_dp_q    <= active_dp_d;
            active_blank_q <= active_blank_d;
            pending_q      <= pending_d;
            frame_tick_q   <= frame_tick_d;
            an_q           <= an_d;
            sg_q           <= sg_d;
        end
    end

    assign an_out     = an_q;
    assign sg_out     = sg_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the calculator top level on the Basys3 board. It scans DIGITS common-anode digits from a packed hex value and drives active-low anode and segment lines. Over a fixed-digit hex decoder it adds:
- double-buffered loads that take effect only at frame boundaries (no tearing),
- per-digit decimal points,
- optional leading-zero blanking,
- PWM brightness control.

It sits between the calculator datapath (or UART command logic) and the `an_out`/`sg_out` board pins.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (≥2)
- SCAN_DIV, 100000, clocks per digit slot (≥2)
- PWM_BITS, 4, brightness resolution in bits (≥1)

Ports:
- sys_clock  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = display on; 0 = all dark, counters keep running
- load  in  1  one-cycle strobe; captures value, dp_in and blank_lz into shadow registers
- value  in  4*DIGITS  packed hex digits; digit 0 (rightmost) = value[3:0]
- dp_in  in  DIGITS  decimal-point request per digit; bit k = digit k
- blank_lz  in  1  leading-zero blanking request, captured on load
- brightness  in  PWM_BITS  duty select; all-ones = 100 %
- an_out  out  DIGITS  active-low anodes; bit k = digit k
- sg_out  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- frame_tick  out  1  one-cycle pulse at each frame start
- pending  out  1  a load is held in shadow and not yet displayed

## Operation
- **Reset values:**
  - an_out all ones; sg_out 0xFF; frame_tick 0; pending 0.
  - Shadow and active value, dp and blank registers 0.
  - Digit index, prescaler and PWM counter 0.
- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. At terminal count the digit index advances; it wraps from DIGITS-1 to 0.
- **Frame boundary:** the edge where prescaler = SCAN_DIV-1 and index = DIGITS-1. On that edge:
  - active ← shadow, and pending clears;
  - frame_tick is registered high for exactly one cycle (the first cycle of the new frame).
- **Load:** shadow ← {value, dp_in, blank_lz} and pending ← 1.
  - Load coinciding with a frame boundary: active takes the old shadow contents, shadow takes the new inputs, and pending stays 1.
  - A second load before the boundary overwrites shadow; only the last load is displayed.
- **Hex decode:** 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (dp bit = 1).
- **Decimal point:** an active dp bit for the current digit clears sg_out[7].
- **Leading-zero blanking:** applies when the active blank flag is set.
  - Digit k (k ≥ 1) is blank when nibbles DIGITS-1..k are all zero.
  - Digit 0 is never blanked.
  - A blank digit drives segments g..a = 1. Its dp still follows dp_in: sg_out = 0x7F when dp is set, else 0xFF with its anode off.
- **PWM:**
  - The PWM_BITS counter free-runs every clock and wraps.
  - The current anode is asserted only while pwm_cnt ≤ brightness. Brightness 0 gives a 1/2^PWM_BITS duty.
  - When the anode is off, sg_out = 0xFF.
- **Enable:** enable = 0 forces an_out all ones and sg_out 0xFF. Loads and frame updates continue.
- **Anode drive:** at most one anode bit is low at any time.

## Timing
- an_out, sg_out and frame_tick are registered. They reflect index, PWM counter, active registers and enable from the previous cycle (1-cycle latency).
- Frame period is DIGITS·SCAN_DIV cycles. After reset is released, the first frame_tick is high in cycle DIGITS·SCAN_DIV (counting the first active edge as cycle 1).
- Load-to-display latency:
  - minimum: 1 cycle from the frame boundary;
  - maximum: DIGITS·SCAN_DIV + 1 cycles from the load.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Any pending load is discarded.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, PWM_BITS=2, brightness=3, enable=1 unless stated.

- **Reset then idle:** an_out = 1111 and sg_out = FF during reset. After release, digits show C0 each in turn (an_out 1110, 1101, 1011, 0111, 4 cycles each), and frame_tick pulses every 16 cycles.
- **Load 0x12AF mid-frame:** pending = 1 until the next boundary. In the following frame the digits show 8E, 88, A4, F9 for digits 0..3. pending = 0 after the boundary.
- **Blanking and dp:** load 0x0050 with blank_lz = 1 and dp_in = 0100 → digits 3 and 2 are dark except digit 2 shows sg_out 7F. Digit 1 shows 92 and digit 0 shows C0. Load 0x0000 → only digit 0 lit, showing C0.
- **Simultaneous load at boundary plus back-to-back loads:**
  - 0x1111 then 0x2222 before the boundary → only 2222 is shown.
  - Load 0x3333 exactly on the boundary edge → 2222 is displayed for the frame and 3333 the frame after; pending stays 1 across the first boundary.
- **Brightness 0:** each lit slot asserts its anode 1 of every 4 cycles (cycles where pwm_cnt = 0), with sg_out FF otherwise. enable = 0 → an_out 1111 and sg_out FF continuously, while frame_tick keeps pulsing.
- **Reset mid-frame with a pending load:** all outputs return to their reset values immediately and pending = 0. The display shows 0000, and the first frame_tick arrives 16 cycles after release.
